pipe_ex: RTL and testbench
==========================

PIPE_EX -- requirements
Module: pipe_ex

Interface
REQ-001 SHALL have parameter REG_SZ, default 32, operand/result width.
REQ-002 SHALL have parameter ALUOP_L, default 5, alu_op width.
REQ-003 SHALL have clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have in_valid, input, 1, ID holds a decoded instruction.
REQ-006 SHALL have in_ready, output, 1, EX accepts this cycle.
REQ-007 SHALL have pc_in, input, 32, instruction PC.
REQ-008 SHALL have alu_op, input, ALUOP_L, ALU operation code.
REQ-009 SHALL have alu_c, input, 1, invert compare result.
REQ-010 SHALL have rd, input, 5, destination register.
REQ-011 SHALL have opr1 and opr2, input, REG_SZ each, signed ALU operands.
REQ-012 SHALL have val, input, REG_SZ, store data, branch offset, or link increment.
REQ-013 SHALL have jp_e, input, 1, JAL/JALR.
REQ-014 SHALL have br_e, input, 1, conditional branch.
REQ-015 SHALL have wb_e, input, 1, instruction writes rd.
REQ-016 SHALL have rw_e, input, 2, memory access: 00 none, 01 store, 10 load signed, 11 load unsigned.
REQ-017 SHALL have rw_len, input, 2, access size: 00 byte, 01 half, 11 word.
REQ-018 SHALL have out_valid, output, 1, MA-bound register holds an instruction.
REQ-019 SHALL have out_ready, input, 1, MA accepts.
REQ-020 SHALL have out_result, output, REG_SZ, ALU result, memory address, or link value.
REQ-021 SHALL have out_data, output, REG_SZ, store data.
REQ-022 SHALL have out_rd, output, 5, destination register.
REQ-023 SHALL have out_wb_e, output, 1, writeback enable.
REQ-024 SHALL have out_mem, output, 4, {rw_e, rw_len}.
REQ-025 SHALL have redir_valid, output, 1, one-cycle redirect request to fetch.
REQ-026 SHALL have redir_pc, output, 32, redirect target.
REQ-027 SHALL have ex_fwd_idx, output, 5, forwarded register index.
REQ-028 SHALL have ex_fwd_val, output, 32, forwarded value.
REQ-029 SHALL have ex_ack, output, 1, one-cycle forward strobe to ID.

Function
REQ-030 SHALL use in_ready = (state==RUN) && (!out_valid || out_ready), accept on in_valid&&in_ready, and register outputs with 1-cycle latency.
REQ-031 SHALL implement ALU: PASS=opr1; ADD; SUB; SLL/SRL/SRA by opr2[4:0]; XOR; OR; AND; SLT signed; SLTU; SEQ; compares yield 0/1 with bit0 XOR alu_c; unknown op yields 0.
REQ-032 SHALL select out_result: jp_e gives pc_in+val; rw_e!=00 gives opr1+opr2; otherwise the ALU result; out_data=val.
REQ-033 SHALL drive out_wb_e = wb_e && !br_e && rd!=0.
REQ-034 SHALL compute redirect target: br_e gives pc_in+val; jp_e gives (opr1+opr2) with bit0 cleared; a branch is taken when the compare result is 1.
REQ-035 SHALL use FSM states RUN and REDIR: accepting jp_e or a taken br_e moves to REDIR, where redir_valid=1 for exactly one cycle, in_ready=0, and in_valid is ignored (flush bubble), then returns to RUN.
REQ-036 SHALL pulse ex_ack one cycle after acceptance when out_wb_e and rw_e[1]==0, with ex_fwd_idx=rd and ex_fwd_val=out_result; loads are never forwarded here.
REQ-037 SHALL hold every out_* signal stable while out_valid && !out_ready; out_ready together with a new accept in the same cycle replaces the register contents without a bubble.
REQ-038 SHALL compute all arithmetic modulo 2^32 and raise no misalignment traps.

Reset
REQ-039 SHALL, on rst at any clock edge (including mid-stall or in REDIR), force state=RUN and out_valid, redir_valid, ex_ack, out_wb_e, out_mem, out_result, out_data, out_rd, redir_pc, ex_fwd_idx and ex_fwd_val all to 0, dropping any held instruction.

Structure
REQ-040 SHALL take ALU opcode and rw_e/rw_len encodings from the shared alu_pkg package, used by ID and EX alike.
REQ-041 SHALL place the purely combinational ALU in one sub-module, ex_alu.

Verification
REQ-042 SHALL cover: ADD, opr1=5, opr2=-3, rd=7, wb_e -> next cycle out_result=2, ex_ack=1, ex_fwd_idx=7, ex_fwd_val=2.
REQ-043 SHALL cover: SEQ with alu_c=1, opr1=1, opr2=2, pc_in=0x100, val=0x10, br_e -> redir_valid for one cycle, redir_pc=0x110, in_ready=0 that cycle, out_wb_e=0.
REQ-044 SHALL cover: JALR, opr1=0x203, opr2=4, val=4, pc_in=0x40, rd=1 -> redir_pc=0x206, out_result=0x44.
REQ-045 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> pending input accepted in that same cycle.
REQ-046 SHALL cover: SRA, opr1=0x80000000, opr2=0x21 -> out_result=0xC0000000; LW, opr1=0x1000, opr2=8 -> out_result=0x1008, ex_ack=0.
REQ-047 SHALL cover: rst asserted in REDIR with out_valid=1 -> next cycle redir_valid=0, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU / memory-access encodings used by both the ID and EX stages.
package alu_pkg;

  localparam int ALUOP_W = 5;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_PASS = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_SLL  = 5'd3,
    ALU_SRL  = 5'd4,
    ALU_SRA  = 5'd5,
    ALU_XOR  = 5'd6,
    ALU_OR   = 5'd7,
    ALU_AND  = 5'd8,
    ALU_SLT  = 5'd9,
    ALU_SLTU = 5'd10,
    ALU_SEQ  = 5'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    RW_NONE   = 2'b00,
    RW_STORE  = 2'b01,
    RW_LOAD_S = 2'b10,
    RW_LOAD_U = 2'b11
  } rw_e_e;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'b00,
    LEN_HALF = 2'b01,
    LEN_WORD = 2'b11
  } rw_len_e;

  typedef enum logic {
    RUN   = 1'b0,
    REDIR = 1'b1
  } ex_state_e;

endpackage

// File: rtl/ex_alu.sv
// Purely combinational EX-stage ALU. Compare ops produce 0/1 with the
// result bit optionally inverted by alu_c; cmp mirrors that bit for branches.
module ex_alu
  import alu_pkg::*;
#(
  parameter int REG_SZ  = 32,
  parameter int ALUOP_L = 5
) (
  input  logic [ALUOP_L-1:0]       alu_op,
  input  logic                     alu_c,
  input  logic signed [REG_SZ-1:0] opr1,
  input  logic signed [REG_SZ-1:0] opr2,
  output logic signed [REG_SZ-1:0] result,
  output logic                     cmp
);

  // Opcode compared at the wider of the port width and the package width.
  localparam int OPW = (ALUOP_L > ALUOP_W) ? ALUOP_L : ALUOP_W;

  logic [OPW-1:0] op;
  logic [4:0]     shamt;
  logic           c;

  // Operation decode and evaluation.
  always_comb begin
    op     = OPW'(alu_op);
    shamt  = opr2[4:0];
    c      = 1'b0;
    result = '0;
    case (op)
      OPW'(ALU_PASS): result = opr1;
      OPW'(ALU_ADD):  result = opr1 + opr2;
      OPW'(ALU_SUB):  result = opr1 - opr2;
      OPW'(ALU_SLL):  result = opr1 << shamt;
      OPW'(ALU_SRL):  result = $signed($unsigned(opr1) >> shamt);
      OPW'(ALU_SRA):  result = opr1 >>> shamt;
      OPW'(ALU_XOR):  result = opr1 ^ opr2;
      OPW'(ALU_OR):   result = opr1 | opr2;
      OPW'(ALU_AND):  result = opr1 & opr2;
      OPW'(ALU_SLT): begin
        c      = (opr1 < opr2) ^ alu_c;
        result = $signed(REG_SZ'(c));
      end
      OPW'(ALU_SLTU): begin
        c      = ($unsigned(opr1) < $unsigned(opr2)) ^ alu_c;
        result = $signed(REG_SZ'(c));
      end
      OPW'(ALU_SEQ): begin
        c      = (opr1 == opr2) ^ alu_c;
        result = $signed(REG_SZ'(c));
      end
      default: result = '0;
    endcase
    cmp = c;
  end

endmodule

// File: rtl/pipe_ex.sv
// EX pipeline stage: ALU, address/link generation, branch/jump redirect,
// and a one-cycle forwarding strobe back to ID. Single output register
// with valid/ready handshake towards MA.
module pipe_ex
  import alu_pkg::*;
#(
  parameter int REG_SZ  = 32,
  parameter int ALUOP_L = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              pc_in,
  input  logic [ALUOP_L-1:0]       alu_op,
  input  logic                     alu_c,
  input  logic [4:0]               rd,
  input  logic signed [REG_SZ-1:0] opr1,
  input  logic signed [REG_SZ-1:0] opr2,
  input  logic [REG_SZ-1:0]        val,
  input  logic                     jp_e,
  input  logic                     br_e,
  input  logic                     wb_e,
  input  logic [1:0]               rw_e,
  input  logic [1:0]               rw_len,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_SZ-1:0]        out_result,
  output logic [REG_SZ-1:0]        out_data,
  output logic [4:0]               out_rd,
  output logic                     out_wb_e,
  output logic [3:0]               out_mem,
  output logic                     redir_valid,
  output logic [31:0]              redir_pc,
  output logic [4:0]               ex_fwd_idx,
  output logic [31:0]              ex_fwd_val,
  output logic                     ex_ack
);

  ex_state_e                state;
  logic                     vld_p1;
  logic                     redir_vld_p1;
  logic                     ack_p1;
  logic [REG_SZ-1:0]        result_p1;
  logic [REG_SZ-1:0]        data_p1;
  logic [4:0]               rd_p1;
  logic                     wb_e_p1;
  logic [3:0]               mem_p1;
  logic [31:0]              redir_pc_p1;
  logic [4:0]               fwd_idx_p1;
  logic [31:0]              fwd_val_p1;

  logic signed [REG_SZ-1:0] alu_res_p0;
  logic                     alu_cmp_p0;
  logic signed [REG_SZ-1:0] sum_p0;
  logic [REG_SZ-1:0]        link_p0;
  logic [REG_SZ-1:0]        result_p0;
  logic [31:0]              target_p0;
  logic                     taken_p0;
  logic                     redir_p0;
  logic                     wb_p0;
  logic                     fwd_p0;
  logic                     accept;

  ex_alu #(
    .REG_SZ  (REG_SZ),
    .ALUOP_L (ALUOP_L)
  ) u_alu (
    .alu_op (alu_op),
    .alu_c  (alu_c),
    .opr1   (opr1),
    .opr2   (opr2),
    .result (alu_res_p0),
    .cmp    (alu_cmp_p0)
  );

  // ---- stage p0: decode of accepted instruction into result/target ----
  always_comb begin
    in_ready  = (state == RUN) && (!vld_p1 || out_ready);
    accept    = in_valid && in_ready;
    sum_p0    = opr1 + opr2;
    link_p0   = REG_SZ'(pc_in) + val;
    taken_p0  = br_e && alu_cmp_p0;
    redir_p0  = jp_e || taken_p0;
    wb_p0     = wb_e && !br_e && (rd != 5'd0);
    fwd_p0    = wb_p0 && !rw_e[1];
    if (jp_e)
      result_p0 = link_p0;
    else if (rw_e != RW_NONE)
      result_p0 = $unsigned(sum_p0);
    else
      result_p0 = $unsigned(alu_res_p0);
    if (br_e)
      target_p0 = pc_in + 32'(val);
    else
      target_p0 = 32'($unsigned(sum_p0)) & ~32'd1;
  end

  // ---- stage p1: control registers (FSM, valids, strobes) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      vld_p1       <= 1'b0;
      redir_vld_p1 <= 1'b0;
      ack_p1       <= 1'b0;
    end else begin
      ack_p1       <= accept && fwd_p0;
      redir_vld_p1 <= accept && redir_p0;
      case (state)
        RUN:     if (accept && redir_p0) state <= REDIR;
        REDIR:   state <= RUN;
        default: state <= RUN;
      endcase
      if (accept)
        vld_p1 <= 1'b1;
      else if (out_ready)
        vld_p1 <= 1'b0;
    end
  end

  // Output payload: loaded on accept, otherwise held (stable under stall).
  always_ff @(posedge clk) begin
    if (rst) begin
      result_p1   <= '0;
      data_p1     <= '0;
      rd_p1       <= '0;
      wb_e_p1     <= 1'b0;
      mem_p1      <= '0;
      redir_pc_p1 <= '0;
      fwd_idx_p1  <= '0;
      fwd_val_p1  <= '0;
    end else if (accept) begin
      result_p1 <= result_p0;
      data_p1   <= val;
      rd_p1     <= rd;
      wb_e_p1   <= wb_p0;
      mem_p1    <= {rw_e, rw_len};
      if (redir_p0)
        redir_pc_p1 <= target_p0;
      if (fwd_p0) begin
        fwd_idx_p1 <= rd;
        fwd_val_p1 <= 32'(result_p0);
      end
    end
  end

  assign out_valid   = vld_p1;
  assign out_result  = result_p1;
  assign out_data    = data_p1;
  assign out_rd      = rd_p1;
  assign out_wb_e    = wb_e_p1;
  assign out_mem     = mem_p1;
  assign redir_valid = redir_vld_p1;
  assign redir_pc    = redir_pc_p1;
  assign ex_fwd_idx  = fwd_idx_p1;
  assign ex_fwd_val  = fwd_val_p1;
  assign ex_ack      = ack_p1;

endmodule

// File: tb/tb_pipe_ex.sv
// Directed testbench for pipe_ex with immediate-assertion checks.
module tb_pipe_ex;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_in;
  logic [4:0]  alu_op;
  logic        alu_c;
  logic [4:0]  rd;
  logic signed [31:0] opr1;
  logic signed [31:0] opr2;
  logic [31:0] val;
  logic        jp_e, br_e, wb_e;
  logic [1:0]  rw_e, rw_len;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result, out_data;
  logic [4:0]  out_rd;
  logic        out_wb_e;
  logic [3:0]  out_mem;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic [4:0]  ex_fwd_idx;
  logic [31:0] ex_fwd_val;
  logic        ex_ack;

  int checks = 0;
  int errors = 0;

  pipe_ex #(.REG_SZ(32), .ALUOP_L(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .alu_op(alu_op), .alu_c(alu_c), .rd(rd),
    .opr1(opr1), .opr2(opr2), .val(val), .jp_e(jp_e), .br_e(br_e),
    .wb_e(wb_e), .rw_e(rw_e), .rw_len(rw_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_data(out_data),
    .out_rd(out_rd), .out_wb_e(out_wb_e), .out_mem(out_mem),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .ex_fwd_idx(ex_fwd_idx), .ex_fwd_val(ex_fwd_val), .ex_ack(ex_ack)
  );

  always #5 clk = ~clk;

  // ALU vector table: op, alu_c, opr1, opr2, expected result
  logic [4:0]  t_op  [0:13] = '{ALU_PASS, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA,
                                ALU_XOR, ALU_OR, ALU_AND, ALU_SLT, ALU_SLT,
                                ALU_SLTU, ALU_SEQ, ALU_SEQ, 5'd31};
  logic        t_c   [0:13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
  logic [31:0] t_a   [0:13] = '{32'h1234, 32'd5, 32'd1, 32'h80000000, 32'h80000000,
                                32'hF0F0, 32'hF0F0, 32'hF0F0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                32'hFFFFFFFF, 32'd7, 32'd7, 32'd9};
  logic [31:0] t_b   [0:13] = '{32'h55, 32'd7, 32'h24, 32'd1, 32'h21,
                                32'hFF00, 32'h0F00, 32'hFF00, 32'd1, 32'd1,
                                32'd1, 32'd7, 32'd7, 32'd3};
  logic [31:0] t_exp [0:13] = '{32'h1234, 32'hFFFFFFFE, 32'h10, 32'h40000000, 32'hC0000000,
                                32'h0FF0, 32'hFFF0, 32'hF000, 32'd1, 32'd0,
                                32'd0, 32'd1, 32'd0, 32'd0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; pc_in = 0; alu_op = ALU_PASS; alu_c = 0; rd = 0;
    opr1 = 0; opr2 = 0; val = 0; jp_e = 0; br_e = 0; wb_e = 0;
    rw_e = RW_NONE; rw_len = LEN_WORD;
  endtask

  task automatic drive(input logic [4:0] op, input logic c,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] v, input logic [31:0] pc,
                       input logic [4:0] d, input logic jp, input logic br,
                       input logic wb, input logic [1:0] rwe, input logic [1:0] rlen);
    in_valid = 1; alu_op = op; alu_c = c; opr1 = a; opr2 = b; val = v;
    pc_in = pc; rd = d; jp_e = jp; br_e = br; wb_e = wb; rw_e = rwe; rw_len = rlen;
  endtask

  initial begin
    rst = 1; out_ready = 1; idle();
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_redir_valid", redir_valid, 0);
    chk("rst_ex_ack", ex_ack, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_mem", out_mem, 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 0;

    // ADD 5 + -3 -> 2, forwarded
    drive(ALU_ADD, 0, 32'd5, 32'hFFFFFFFD, 0, 0, 5'd7, 0, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 32'd2);
    chk("add_ack", ex_ack, 1);
    chk("add_fwd_idx", ex_fwd_idx, 32'd7);
    chk("add_fwd_val", ex_fwd_val, 32'd2);
    chk("add_wb", out_wb_e, 1);
    chk("add_rd", out_rd, 32'd7);
    idle();
    step();
    chk("idle_ack", ex_ack, 0);
    chk("idle_valid", out_valid, 0);

    // back-to-back ALU ops
    for (int i = 0; i < 14; i++) begin
      drive(t_op[i], t_c[i], t_a[i], t_b[i], 0, 0, 5'd9, 0, 0, 1, RW_NONE, LEN_WORD);
      step();
      chk($sformatf("alu%0d", i), out_result, t_exp[i]);
    end

    // rd = x0 never writes back
    drive(ALU_ADD, 0, 1, 1, 0, 0, 5'd0, 0, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("x0_wb", out_wb_e, 0);
    chk("x0_ack", ex_ack, 0);

    // LW: address, no forward
    drive(ALU_ADD, 0, 32'h1000, 32'd8, 0, 0, 5'd5, 0, 0, 1, RW_LOAD_S, LEN_WORD);
    step();
    chk("lw_result", out_result, 32'h1008);
    chk("lw_ack", ex_ack, 0);
    chk("lw_wb", out_wb_e, 1);
    chk("lw_mem", out_mem, 4'b1011);

    // SB: address from opr1+opr2 regardless of alu_op, data = val
    drive(ALU_PASS, 0, 32'h2000, 32'd4, 32'hDEAD, 0, 5'd0, 0, 0, 0, RW_STORE, LEN_BYTE);
    step();
    chk("sb_result", out_result, 32'h2004);
    chk("sb_data", out_data, 32'hDEAD);
    chk("sb_mem", out_mem, 4'b0100);

    // not-taken branch
    drive(ALU_SEQ, 0, 1, 2, 32'h10, 32'h100, 5'd3, 0, 1, 1, RW_NONE, LEN_WORD);
    step();
    chk("bnt_redir", redir_valid, 0);
    chk("bnt_in_ready", in_ready, 1);
    chk("bnt_wb", out_wb_e, 0);

    // taken branch (SEQ inverted): 1 != 2 -> taken
    drive(ALU_SEQ, 1, 1, 2, 32'h10, 32'h100, 5'd3, 0, 1, 1, RW_NONE, LEN_WORD);
    step();
    chk("bt_redir", redir_valid, 1);
    chk("bt_redir_pc", redir_pc, 32'h110);
    chk("bt_wb", out_wb_e, 0);
    chk("bt_ack", ex_ack, 0);
    drive(ALU_ADD, 0, 32'd40, 32'd2, 0, 0, 5'd8, 0, 0, 1, RW_NONE, LEN_WORD);
    #1;
    chk("bt_in_ready", in_ready, 0);
    step();
    chk("bt_redir_end", redir_valid, 0);
    chk("bt_bubble", out_valid, 0);
    chk("bt_ready_back", in_ready, 1);
    step();
    chk("bt_next_result", out_result, 32'd42);
    chk("bt_next_rd", out_rd, 32'd8);

    // JALR
    drive(ALU_ADD, 0, 32'h203, 32'd4, 32'd4, 32'h40, 5'd1, 1, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("jalr_redir", redir_valid, 1);
    chk("jalr_pc", redir_pc, 32'h206);
    chk("jalr_result", out_result, 32'h44);
    chk("jalr_ack", ex_ack, 1);
    chk("jalr_fwd_idx", ex_fwd_idx, 32'd1);
    chk("jalr_fwd_val", ex_fwd_val, 32'h44);
    idle();
    step();
    chk("jalr_redir_end", redir_valid, 0);

    // stall: hold A while B waits
    drive(ALU_ADD, 0, 32'd10, 32'd20, 0, 0, 5'd4, 0, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("stall_a", out_result, 32'd30);
    out_ready = 0;
    drive(ALU_SUB, 0, 32'd100, 32'd1, 0, 0, 5'd6, 0, 0, 1, RW_NONE, LEN_WORD);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall_ready%0d", k), in_ready, 0);
      step();
      chk($sformatf("stall_valid%0d", k), out_valid, 1);
      chk($sformatf("stall_result%0d", k), out_result, 32'd30);
      chk($sformatf("stall_rd%0d", k), out_rd, 32'd4);
      chk($sformatf("stall_ack%0d", k), ex_ack, 0);
    end
    out_ready = 1;
    #1;
    chk("release_ready", in_ready, 1);
    step();
    chk("release_result", out_result, 32'd99);
    chk("release_rd", out_rd, 32'd6);
    chk("release_valid", out_valid, 1);
    chk("release_ack", ex_ack, 1);

    // reset while in REDIR
    drive(ALU_PASS, 0, 32'd0, 32'h300, 32'd4, 32'h80, 5'd1, 1, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("jal_redir", redir_valid, 1);
    chk("jal_valid", out_valid, 1);
    chk("jal_pc", redir_pc, 32'h300);
    chk("jal_result", out_result, 32'h84);
    rst = 1; idle();
    step();
    chk("rr_redir", redir_valid, 0);
    chk("rr_valid", out_valid, 0);
    chk("rr_in_ready", in_ready, 1);
    chk("rr_result", out_result, 0);
    chk("rr_fwd_val", ex_fwd_val, 0);
    chk("rr_redir_pc", redir_pc, 0);
    rst = 0;

    // accept resumes after reset
    drive(ALU_ADD, 0, 32'd3, 32'd4, 0, 0, 5'd2, 0, 0, 1, RW_NONE, LEN_WORD);
    step();
    chk("post_rst_result", out_result, 32'd7);
    chk("post_rst_valid", out_valid, 1);
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
